// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types and constants (fetch FSM states, instruction width, NOP, PC step)
package pipe_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
    localparam int PC_INC = 4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, registered storage, async active-low reset
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/s0_fetch_stage.sv
// s0_fetch_stage: PC, single-outstanding imem fetch and instruction buffer feeding S1 decode
// Optional FETCH_PERF_CNT_EN adds the fetch_count accepted-instruction counter
module s0_fetch_stage
    import pipe_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [31:0]        fetch_count
);
    localparam int FW = INSTR_W + ADDR_W;
    fetch_state_t state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, req_pc, req_pc_nxt, pc_last;
    logic push, pop, full, empty, granted;
    logic [FW-1:0] head;
    logic [$clog2(FIFO_DEPTH):0] count;
    assign imem_req    = state == REQ && count < ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);
    assign imem_addr   = pc;
    assign granted     = imem_req && imem_gnt;
    assign push        = state == WAIT && imem_rvalid && !redirect_valid;
    assign instr_valid = !empty;
    assign pop         = instr_valid && !stall;
    assign instr_out   = empty ? NOP_INSTR : head[INSTR_W-1:0];
    assign pc_out      = empty ? pc_last : head[FW-1 -: ADDR_W];
    // Redirect goes to DRAIN only while a response is still owed after this edge
    always_comb begin
        state_nxt  = state == IDLE ? REQ : state == REQ ? (granted ? WAIT : REQ) : imem_rvalid ? REQ : state;
        pc_nxt     = granted ? pc + ADDR_W'(PC_INC) : pc;
        req_pc_nxt = granted ? pc : req_pc;
        if (redirect_valid) begin
            state_nxt = (granted || ((state == WAIT || state == DRAIN) && !imem_rvalid)) ? DRAIN : REQ;
            pc_nxt    = {redirect_pc[ADDR_W-1:2], 2'b00};
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            req_pc <= req_pc_nxt;
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) pc_last <= '0;
        else if (pop) pc_last <= head[FW-1 -: ADDR_W];
    fetch_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({req_pc, imem_rdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) fetch_count <= '0;
        else if (pop) fetch_count <= fetch_count + 32'd1;
`else
    assign fetch_count = 32'h0;
`endif
endmodule

// File: tb/tb_s0_fetch_stage.sv
// tb_s0_fetch_stage: directed tests of the fetch stage against a small latency-configurable memory model
module tb_s0_fetch_stage;
    logic clk = 0, rst = 1;
    logic imem_gnt = 1, stall = 0, redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic imem_req, imem_rvalid, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr_out, pc_out, fetch_count;
    logic req2, rvalid2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc2, cnt2;
    logic pend, pend2;
    logic [31:0] paddr, paddr2;
    int cnt, lat = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    s0_fetch_stage dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_out(instr_out),
        .instr_valid(instr_valid), .pc_out(pc_out), .fetch_count(fetch_count));

    s0_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_gnt(imem_gnt),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .instr_out(instr2),
        .instr_valid(valid2), .pc_out(pc2), .fetch_count(cnt2));

    // Memory returns ~addr, lat extra cycles after the grant cycle
    always @(posedge clk or negedge rst)
        if (!rst) begin
            pend <= 0; cnt <= 0; paddr <= 0;
        end else if (imem_req && imem_gnt) begin
            pend <= 1; cnt <= lat; paddr <= imem_addr;
        end else if (pend && cnt == 0) pend <= 0;
        else if (pend) cnt <= cnt - 1;
    assign imem_rvalid = pend && cnt == 0;
    assign imem_rdata  = ~paddr;

    always @(posedge clk or negedge rst)
        if (!rst) begin
            pend2 <= 0; paddr2 <= 0;
        end else begin
            pend2 <= req2 && imem_gnt;
            if (req2 && imem_gnt) paddr2 <= addr2;
        end
    assign rvalid2 = pend2;
    assign rdata2  = ~paddr2;

    task automatic do_reset();
        rst = 0; stall = 0; redirect_valid = 0; imem_gnt = 1; lat = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        #2 rst = 0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
        total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instr_out); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", instr_valid); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc_out); end
        total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%h want=0", fetch_count); end
        total++; if (addr2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_addr2 got=%h want=fffffffc", addr2); end
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_basic();
        logic [31:0] addrs[$], ins[$], pcs[$];
        logic [31:0] ea[3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] ei[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFF7};
        int first_rv = -1, first_v = -1;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            if (imem_req && imem_gnt) addrs.push_back(imem_addr);
            if (imem_rvalid && first_rv < 0) first_rv = c;
            if (instr_valid) begin
                if (first_v < 0) first_v = c;
                ins.push_back(instr_out); pcs.push_back(pc_out);
            end
            if (ins.size() >= 3) break;
            @(negedge clk);
        end
        total++; if (ins.size() < 3) begin bad++; $display("FAIL basic_count got=%0d want=3", ins.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if ((i < addrs.size() ? addrs[i] : 32'hx) !== ea[i]) begin bad++; $display("FAIL basic_addr%0d want=%h", i, ea[i]); end
            total++; if ((i < ins.size() ? ins[i] : 32'hx) !== ei[i]) begin bad++; $display("FAIL basic_instr%0d want=%h", i, ei[i]); end
            total++; if ((i < pcs.size() ? pcs[i] : 32'hx) !== ea[i]) begin bad++; $display("FAIL basic_pc%0d want=%h", i, ea[i]); end
        end
        total++; if (first_v - first_rv !== 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", first_v - first_rv); end
    endtask

    task automatic test_stall();
        logic [31:0] addrs[$], ins[$], pcs[$];
        logic [31:0] ea[3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] ei[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFF7};
        do_reset();
        stall = 1;
        repeat (10) @(negedge clk);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", instr_valid); end
        total++; if (instr_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stall_head got=%h want=ffffffff", instr_out); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL stall_pc got=%h want=0", pc_out); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b want=0", imem_req); end
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stall_addr got=%h want=8", imem_addr); end
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            if (imem_req && imem_gnt) addrs.push_back(imem_addr);
            if (instr_valid && !stall) begin ins.push_back(instr_out); pcs.push_back(pc_out); end
            if (ins.size() >= 3) break;
            @(negedge clk);
        end
        total++; if ((addrs.size() > 0 ? addrs[0] : 32'hx) !== 32'h8) begin bad++; $display("FAIL stall_resume_addr want=8"); end
        for (int i = 0; i < 3; i++) begin
            total++; if ((i < ins.size() ? ins[i] : 32'hx) !== ei[i]) begin bad++; $display("FAIL stall_instr%0d want=%h", i, ei[i]); end
            total++; if ((i < pcs.size() ? pcs[i] : 32'hx) !== ea[i]) begin bad++; $display("FAIL stall_pc%0d want=%h", i, ea[i]); end
        end
    endtask

    task automatic test_redirect_wait();
        logic found = 0, got_g = 0;
        logic [31:0] g_addr = 32'hx;
        do_reset();
        lat = 2; stall = 1;
        for (int c = 0; c < 40 && !found; c++) begin
            found = imem_req && imem_gnt && imem_addr == 32'h4;
            if (!found) @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL rdw_timeout got=none want=grant@4"); end
        @(negedge clk);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rdw_buffered got=%b want=1", instr_valid); end
        redirect_valid = 1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect_valid = 0; stall = 0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rdw_flush got=%b want=0", instr_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdw_drain_req got=%b want=0", imem_req); end
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (imem_req && imem_gnt && !got_g) begin got_g = 1; g_addr = imem_addr; end
            found = instr_valid;
            if (!found) @(negedge clk);
        end
        total++; if (g_addr !== 32'h100) begin bad++; $display("FAIL rdw_addr got=%h want=100", g_addr); end
        total++; if (pc_out !== 32'h100) begin bad++; $display("FAIL rdw_pc got=%h want=100", pc_out); end
        total++; if (instr_out !== 32'hFFFF_FEFF) begin bad++; $display("FAIL rdw_instr got=%h want=fffffeff", instr_out); end
    endtask

    task automatic test_redirect_rvalid();
        logic found = 0, got_g = 0;
        logic [31:0] g_addr = 32'hx;
        do_reset();
        for (int c = 0; c < 40 && !found; c++) begin
            found = imem_req && imem_gnt && imem_addr == 32'h0;
            if (!found) @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL rdr_timeout got=none want=grant@0"); end
        @(negedge clk);
        redirect_valid = 1; redirect_pc = 32'h200; imem_gnt = 0;
        @(negedge clk);
        redirect_valid = 0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rdr_dropped got=%b want=0", instr_valid); end
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rdr_req%0d got=%b want=1", i, imem_req); end
            total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL rdr_addr%0d got=%h want=200", i, imem_addr); end
            @(negedge clk);
        end
        imem_gnt = 1;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (imem_req && imem_gnt && !got_g) begin got_g = 1; g_addr = imem_addr; end
            found = instr_valid;
            if (!found) @(negedge clk);
        end
        total++; if (g_addr !== 32'h200) begin bad++; $display("FAIL rdr_gaddr got=%h want=200", g_addr); end
        total++; if (pc_out !== 32'h200) begin bad++; $display("FAIL rdr_pc got=%h want=200", pc_out); end
        total++; if (instr_out !== 32'hFFFF_FDFF) begin bad++; $display("FAIL rdr_instr got=%h want=fffffdff", instr_out); end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        logic got_v = 0;
        logic [31:0] vpc = 32'hx, vins = 32'hx;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            if (req2 && imem_gnt) addrs.push_back(addr2);
            if (valid2 && !got_v) begin got_v = 1; vpc = pc2; vins = instr2; end
            if (addrs.size() >= 2 && got_v) break;
            @(negedge clk);
        end
        total++; if ((addrs.size() > 0 ? addrs[0] : 32'hx) !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 want=fffffffc"); end
        total++; if ((addrs.size() > 1 ? addrs[1] : 32'hx) !== 32'h0) begin bad++; $display("FAIL wrap_addr1 want=0"); end
        total++; if (vpc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h want=fffffffc", vpc); end
        total++; if (vins !== 32'h0000_0003) begin bad++; $display("FAIL wrap_instr got=%h want=3", vins); end
    endtask

    task automatic test_async_reset();
        int pops = 0;
        logic g = 0, found = 0;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] exp_cnt = 32'd3;
`else
        logic [31:0] exp_cnt = 32'd0;
`endif
        do_reset();
        lat = 2;
        for (int c = 0; c < 80 && pops < 3; c++) begin
            if (instr_valid && !stall) pops++;
            @(negedge clk);
        end
        total++; if (fetch_count !== exp_cnt) begin bad++; $display("FAIL cnt_three got=%0d want=%0d", fetch_count, exp_cnt); end
        stall = 1;
        for (int c = 0; c < 40 && !found; c++) begin
            found = instr_valid && g;
            g = imem_req && imem_gnt;
            if (!found) @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL arst_timeout got=none want=wait_with_data"); end
        #2 rst = 0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL arst_req got=%b want=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL arst_addr got=%h want=0", imem_addr); end
        total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL arst_instr got=%h want=0", instr_out); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", instr_valid); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL arst_pc got=%h want=0", pc_out); end
        total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL arst_cnt got=%0d want=0", fetch_count); end
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
